// File: rtl/wb_dmem_master_pkg.sv
// Shared definitions for the MEM-stage Wishbone data master: FSM encodings,
// reset polarity and default bus timeout.
package wb_dmem_master_pkg;

   typedef enum logic [1:0] {
      WbIdle = 2'd0,
      WbBusy = 2'd1,
      WbDone = 2'd2
   } wb_state_e;

   localparam logic        RstEnable        = 1'b0;
   localparam logic [31:0] ZeroWord         = 32'h0000_0000;
   localparam int          WbTimeoutDefault = 16;

endpackage

// File: rtl/wb_dmem_master.sv
// Wishbone B3 classic single-transfer master for the MiniMIPS32 MEM stage.
// One bus cycle per request, pipeline stalled until ack or timeout abort.
module wb_dmem_master
   import wb_dmem_master_pkg::*;
#(
   parameter int          TIMEOUT  = WbTimeoutDefault,
   parameter logic [31:0] ERR_DATA = ZeroWord
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cpu_ce,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_sel,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic [31:0] cpu_rdata,
   output logic        stall_req,
   output logic        bus_err,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i
);

   localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

   wb_state_e  state, state_nxt;
   logic [7:0] tmo_cnt;
   logic       flush_pend;
   logic       issue, ack, tmo, flushed;

   assign issue   = (state == WbIdle) & cpu_ce & ~flush_i;
   assign ack     = (state == WbBusy) & wb_ack_i;
   // Ack on the limit cycle takes priority over the timeout.
   assign tmo     = (state == WbBusy) & ~wb_ack_i & (tmo_cnt == TmoLast);
   assign flushed = flush_pend | flush_i;

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (wb_rst_i == RstEnable) state <= WbIdle;
      else                       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WbIdle: if (issue) state_nxt = WbBusy;
         WbBusy: if (ack | tmo) state_nxt = flushed ? WbIdle : WbDone;
         WbDone: if (~stall_i | flush_i) state_nxt = WbIdle;
         default: state_nxt = WbIdle;
      endcase
   end

   always_comb begin
      stall_req = issue | (state == WbBusy);
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (wb_rst_i == RstEnable) begin
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         wb_we_o    <= 1'b0;
         wb_adr_o   <= ZeroWord;
         wb_dat_o   <= ZeroWord;
         wb_sel_o   <= 4'h0;
         cpu_rdata  <= ZeroWord;
         bus_err    <= 1'b0;
         tmo_cnt    <= 8'd0;
         flush_pend <= 1'b0;
      end else begin
         bus_err <= 1'b0;
         case (state)
            WbIdle: begin
               if (issue) begin
                  wb_cyc_o   <= 1'b1;
                  wb_stb_o   <= 1'b1;
                  wb_we_o    <= cpu_we;
                  wb_adr_o   <= cpu_addr;
                  wb_dat_o   <= cpu_wdata;
                  wb_sel_o   <= cpu_sel;
                  tmo_cnt    <= 8'd0;
                  flush_pend <= 1'b0;
               end
            end
            WbBusy: begin
               if (ack | tmo) begin
                  wb_cyc_o   <= 1'b0;
                  wb_stb_o   <= 1'b0;
                  wb_we_o    <= 1'b0;
                  wb_sel_o   <= 4'h0;
                  flush_pend <= 1'b0;
                  // A flushed access still finishes on the bus but reports nothing.
                  if (!flushed) begin
                     if (tmo) begin
                        cpu_rdata <= ERR_DATA;
                        bus_err   <= 1'b1;
                     end else if (!wb_we_o) begin
                        cpu_rdata <= wb_dat_i;
                     end
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
                  if (flush_i) flush_pend <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_dmem_master.sv
// Directed and randomized bench for wb_dmem_master against a simple slave
// and a transaction-level reference model.
module tb_wb_dmem_master;

   localparam int          TIMEOUT  = 16;
   localparam logic [31:0] ERR_DATA = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cpu_ce = 1'b0, cpu_we = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [3:0]  cpu_sel = '0;
   logic [31:0] cpu_rdata, wb_adr_o, wb_dat_o, wb_dat_i;
   logic        stall_req, bus_err, wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
   logic [3:0]  wb_sel_o;

   // slave model
   int          slave_waits = 0;
   int          wait_cnt = 0;
   logic        ack_en = 1'b1;
   logic        stray_ack = 1'b0;
   logic [31:0] slave_data = '0;

   // bus monitor
   int          cyc_starts = 0;
   int          busy_cycles = 0;
   logic        prev_cyc = 1'b0;
   logic [31:0] log_adr = '0, log_dat = '0;
   logic [3:0]  log_sel = '0;
   logic        log_we = 1'b0;

   // reference model
   logic [31:0] m_rdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign wb_ack_i = (wb_cyc_o & wb_stb_o & ack_en & (wait_cnt == slave_waits)) | stray_ack;
   assign wb_dat_i = slave_data;

   always @(posedge clk) begin
      if (wb_cyc_o && wb_stb_o && !wb_ack_i) wait_cnt <= wait_cnt + 1;
      else                                   wait_cnt <= 0;
   end

   always @(posedge clk) begin
      prev_cyc <= wb_cyc_o;
      if (wb_cyc_o && !prev_cyc) cyc_starts <= cyc_starts + 1;
      if (wb_cyc_o) busy_cycles <= busy_cycles + 1;
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
         log_adr <= wb_adr_o;
         log_dat <= wb_dat_o;
         log_sel <= wb_sel_o;
         log_we  <= wb_we_o;
      end
   end

   wb_dmem_master #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .cpu_ce   (cpu_ce),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_sel  (cpu_sel),
      .stall_i  (stall_i),
      .flush_i  (flush_i),
      .cpu_rdata(cpu_rdata),
      .stall_req(stall_req),
      .bus_err  (bus_err),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_we_o  (wb_we_o),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_sel_o (wb_sel_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full request; called on a falling edge with the DUT idle, returns
   // on a falling edge with the DUT idle again. waits >= TIMEOUT: no ack.
   task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input int waits, input logic [31:0] sdata,
                          input int hold);
      int   stalls, starts0, busy0, exp_stall, exp_busy;
      logic stable_ok, to, exp_err;
      to          = (waits >= TIMEOUT);
      ack_en      = !to;
      slave_waits = waits;
      slave_data  = sdata;
      starts0     = cyc_starts;
      busy0       = busy_cycles;
      cpu_ce = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_sel = sel;
      stall_i = 1'b0; flush_i = 1'b0;
      stalls = 0; stable_ok = 1'b1;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (!stall_req) break;
         stalls++;
         if (wb_cyc_o && ({wb_we_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o} !==
                          {we, 1'b1, addr, wdata, sel}))
            stable_ok = 1'b0;
         @(negedge clk);
         if (c == 0) begin
            cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom; cpu_sel = 4'($urandom);
         end
      end
      if (to) begin
         exp_stall = 1 + TIMEOUT; exp_busy = TIMEOUT; exp_err = 1'b1; m_rdata = ERR_DATA;
      end else begin
         exp_stall = 2 + waits; exp_busy = waits + 1; exp_err = 1'b0;
         if (!we) m_rdata = sdata;
      end
      chk("stall_cycles", stalls, exp_stall);
      chk("busy_cycles", busy_cycles - busy0, exp_busy);
      chk("cyc_starts", cyc_starts - starts0, 1);
      chk("bus_stable", {31'd0, stable_ok}, 1);
      chk("cyc_after", {31'd0, wb_cyc_o}, 0);
      chk("rdata_done", cpu_rdata, m_rdata);
      chk("bus_err_done", {31'd0, bus_err}, {31'd0, exp_err});
      if (!to) begin
         chk("ack_adr", log_adr, addr);
         chk("ack_we", {31'd0, log_we}, {31'd0, we});
         chk("ack_sel", {28'd0, log_sel}, {28'd0, sel});
         if (we) chk("ack_wdata", log_dat, wdata);
      end
      stall_i = (hold > 0);
      for (int h = 0; h < hold; h++) begin
         stray_ack = 1'($urandom);
         @(negedge clk);
         #1;
         chk("hold_stall", {31'd0, stall_req}, 0);
         chk("hold_cyc", {31'd0, wb_cyc_o}, 0);
         chk("hold_rdata", cpu_rdata, m_rdata);
         chk("hold_bus_err", {31'd0, bus_err}, 0);
      end
      cpu_ce = 1'b0; stall_i = 1'b0; stray_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("no_reissue", cyc_starts - starts0, 1);
      ack_en = 1'b1;
   endtask

   initial begin
      int busy0;
      logic [31:0] rd;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_cyc", {31'd0, wb_cyc_o}, 0);
      chk("rst_stb", {31'd0, wb_stb_o}, 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_stall", {31'd0, stall_req}, 0);
      chk("rst_bus_err", {31'd0, bus_err}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // zero-wait load, store, wait states with held pipeline, timeout
      run_req(1'b0, 32'h0000_f020, 32'h0, 4'hF, 0, 32'h0000_005A, 0);
      run_req(1'b1, 32'h0000_f010, 32'h1234_5678, 4'hF, 0, 32'hFFFF_FFFF, 0);
      run_req(1'b0, 32'h0000_f030, 32'h0, 4'h3, 3, 32'hCAFE_F00D, 3);
      run_req(1'b0, 32'h0000_f040, 32'h0, 4'hF, 99, 32'h1111_1111, 1);
      // ack exactly on the limit cycle, then one cycle past it
      run_req(1'b0, 32'h0000_f050, 32'h0, 4'hF, TIMEOUT - 1, 32'h7777_1234, 1);
      run_req(1'b1, 32'h0000_f060, 32'hA5A5_5A5A, 4'hC, TIMEOUT, 32'h0, 0);

      // stray ack while idle
      stray_ack = 1'b1; slave_data = 32'hBAD0_BAD0;
      @(negedge clk);
      #1;
      chk("stray_rdata", cpu_rdata, m_rdata);
      chk("stray_cyc", {31'd0, wb_cyc_o}, 0);
      stray_ack = 1'b0;
      @(negedge clk);

      // flush in BUSY cycle 2 of a store with 3 wait states
      busy0 = busy_cycles;
      ack_en = 1'b1; slave_waits = 3;
      cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_f070; cpu_wdata = 32'h0BAD_CAFE; cpu_sel = 4'hF;
      @(negedge clk);
      @(negedge clk);
      flush_i = 1'b1; cpu_ce = 1'b0; stall_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (!wb_cyc_o) break;
         @(negedge clk);
      end
      chk("flush_busy", busy_cycles - busy0, 4);
      chk("flush_store_adr", log_adr, 32'h0000_f070);
      chk("flush_store_dat", log_dat, 32'h0BAD_CAFE);
      chk("flush_bus_err", {31'd0, bus_err}, 0);
      chk("flush_rdata", cpu_rdata, m_rdata);
      cpu_ce = 1'b1; cpu_we = 1'b0;
      #1;
      chk("flush_to_idle", {31'd0, stall_req}, 1);
      #1;
      cpu_ce = 1'b0; stall_i = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // asynchronous reset in the middle of a bus cycle
      ack_en = 1'b0;
      cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_f080; cpu_wdata = 32'h5555_AAAA; cpu_sel = 4'h5;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_cyc", {31'd0, wb_cyc_o}, 1);
      cpu_ce = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      m_rdata = '0;
      chk("mid_rst_cyc", {31'd0, wb_cyc_o}, 0);
      chk("mid_rst_stb", {31'd0, wb_stb_o}, 0);
      chk("mid_rst_we", {31'd0, wb_we_o}, 0);
      chk("mid_rst_sel", {28'd0, wb_sel_o}, 0);
      chk("mid_rst_stall", {31'd0, stall_req}, 0);
      chk("mid_rst_rdata", cpu_rdata, m_rdata);
      @(negedge clk);
      rst_n = 1'b1; ack_en = 1'b1;
      @(negedge clk);
      run_req(1'b0, 32'h0000_f090, 32'h0, 4'hF, 0, 32'h0042_4242, 0);

      // randomized traffic
      for (int i = 0; i < 20; i++) begin
         logic we_r;
         int   w;
         we_r = 1'($urandom);
         w    = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 4));
         rd   = $urandom;
         run_req(we_r, $urandom, $urandom, 4'($urandom), w, rd, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wb_dmem_master.md
Name: wb_dmem_master

Overview:
- Wishbone B3 classic single-transfer bus master that turns the MiniMIPS32 MEM-stage data-memory request into Wishbone cycles toward the peripheral address decoder and RAM slaves.
- Issues one cycle per request and holds the pipeline through a stall request until the slave acks.
- Returns registered read data and enforces a bus timeout, so a missing ack cannot hang the core.

Parameters:
- TIMEOUT, 16, maximum cycles spent in BUSY before abort (legal range 2..255).
- ERR_DATA, 32'h00000000, value returned on cpu_rdata after a timeout.

Ports:
- wb_clk_i  in  1  clock, rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-low (RstEnable = 0).
- cpu_ce  in  1  MEM-stage access request.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, already lane-aligned.
- cpu_sel  in  4  byte enables.
- stall_i  in  1  pipeline stall from other sources (held MEM stage).
- flush_i  in  1  exception flush.
- cpu_rdata  out  32  load data, registered.
- stall_req  out  1  stall request to pipeline control.
- bus_err  out  1  one-cycle timeout pulse.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone control.
- wb_adr_o  out  32  Wishbone address.
- wb_dat_o  out  32  Wishbone write data.
- wb_sel_o  out  4  Wishbone byte selects.
- wb_dat_i  in  32  Wishbone read data.
- wb_ack_i  in  1  Wishbone acknowledge (slave may drive it combinationally from cyc&stb).

Behaviour:
- Reset (async, any state):
  - all wb_* outputs, cpu_rdata, bus_err and the timeout counter go to 0.
  - state goes to IDLE.
  - stall_req = 0 once in IDLE. A reset mid-BUSY drops cyc/stb immediately.
- Three states: IDLE, BUSY, DONE.
- stall_req is combinational: (IDLE & cpu_ce & ~flush_i) | BUSY.
- IDLE:
  - cpu_ce=1 & flush_i=0 -> register cyc=stb=1, we/adr/dat/sel from the cpu_* inputs; clear counter; go BUSY.
  - Otherwise stay; wb_* outputs remain 0.
- BUSY: wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o are stable for the whole cycle.
  - wb_ack_i=1:
    - next edge clears cyc/stb/we/sel.
    - load: cpu_rdata <= wb_dat_i; store: cpu_rdata unchanged.
    - go DONE.
  - wb_ack_i=0 & counter==TIMEOUT-1:
    - clear cyc/stb/we/sel; cpu_rdata <= ERR_DATA.
    - bus_err=1 for exactly the next cycle; go DONE.
  - Otherwise: counter++.
- DONE:
  - stall_req=0; cpu_rdata is valid.
  - stall_i=0 or flush_i=1 -> IDLE.
  - stall_i=1 -> stay in DONE; hold cpu_rdata; never reissue, even though cpu_ce is still high.
- Flush:
  - flush_i in BUSY does not abort the started bus cycle (stores complete).
  - A pending-flush flag is set; on ack or timeout, go IDLE instead of DONE with cpu_rdata unchanged and no bus_err.
  - The flag clears on leaving BUSY.
- Latency, zero-wait slave: request cycle (IDLE) + 1 BUSY cycle -> stall_req high for 2 cycles; data visible in the DONE cycle.
- Each slave wait state adds one stall cycle.
- Back-to-back requests have at least one idle cycle of cyc=0 between them (the DONE cycle).
- Ack arriving on the same cycle as the timeout limit: ack wins, no bus_err.
- wb_ack_i outside BUSY is ignored.

Decomposition:
- Shared defines.v gets:
  - state encodings WbIdle/WbBusy/WbDone (2-bit);
  - RstEnable, ZeroWord;
  - WbTimeoutDefault = 16.
- No sub-module: a single FSM plus an 8-bit counter in one file (about 150 lines).

Test Plan:
- Zero-wait load: cpu_ce=1, we=0, addr=0x0000f020, sel=4'hF; slave returns 0x0000005A with ack=cyc&stb -> one BUSY cycle with adr=0xf020, we=0; stall_req high 2 cycles; cpu_rdata=0x0000005A in DONE.
- Store: addr=0x0000f010, wdata=0x12345678, sel=4'hF -> exactly one cycle with cyc=stb=we=1, dat_o=0x12345678; cpu_rdata unchanged; back to IDLE after DONE.
- Wait states: slave acks after 3 wait cycles with data 0xCAFEF00D -> stall_req high 5 cycles; adr/sel/we stable throughout BUSY; cpu_rdata=0xCAFEF00D.
- Held pipeline: stall_i=1 for 3 cycles after ack with cpu_ce still 1 -> remains in DONE; no second cyc assertion; cpu_rdata held.
- Timeout: slave never acks -> cyc drops after exactly 16 BUSY cycles; bus_err high one cycle; cpu_rdata=0x00000000; core unstalls.
- Flush/reset: flush_i pulsed in cycle 2 of BUSY for a store -> store completes, no DONE, no bus_err. Separately, wb_rst_i low mid-BUSY -> cyc/stb/we/sel 0 asynchronously, state IDLE.
